dco_word_seq: RTL and testbench
===============================

DCO_WORD_SEQ -- requirements
Module: dco_word_seq

Interface
REQ-001 Parameter MAX, default 25: largest legal tuning word; larger targets are clamped to this value.
REQ-002 Parameter STEP_DIV, default 4: clock cycles per one-LSB ramp step (range 1..15).
REQ-003 Parameter SETTLE_CYC, default 8: hold cycles after the target is reached, before done (range 0..255).
REQ-004 Parameter RST_WORD, default 0: value of word_out after reset.
REQ-005 clk  in  1  system clock; all state updates on the posedge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  global enable; low freezes all state.
REQ-008 req_a  in  1  calibration requester, high priority; held high until ack_a.
REQ-009 word_a  in  5  calibration target word; sampled on grant.
REQ-010 req_b  in  1  tracking requester, low priority; held high until ack_b.
REQ-011 word_b  in  5  tracking target word; sampled on grant.
REQ-012 ack_a / ack_b  out  1 each  one-cycle grant pulse to the owning requester.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the settle period ends.
REQ-015 word_out  out  5  tuning word to the row/column coder.
REQ-016 cod_en  out  1  coder load enable; one-cycle pulse per word_out change.

Function
REQ-017 FSM states: IDLE, RAMP, SETTLE, DONE, with a 2-bit encoding.
REQ-018 IDLE with req_a high: assert ack_a next cycle, latch min(word_a, MAX) as target, go to RAMP.
REQ-019 IDLE with req_b high and req_a low: same as REQ-018 using ack_b and word_b.
REQ-020 req_a and req_b high together: a is granted; b gets no ack until the FSM returns to IDLE and req_a is low.
REQ-021 Requests in any state other than IDLE are not acknowledged; no request queue.
REQ-022 RAMP, step counter reaches STEP_DIV-1: word_out moves 1 LSB toward the target, cod_en pulses in the same cycle, counter clears.
REQ-023 RAMP, word_out equals target: go to SETTLE with no further change; this includes a target equal to word_out at grant (zero steps, cod_en never pulses).
REQ-024 Step arithmetic: unsigned 5-bit; word_out never below 0 or above MAX; no wrap-around.
REQ-025 SETTLE: count SETTLE_CYC cycles, then go to DONE; SETTLE_CYC=0 goes to DONE on the next cycle.
REQ-026 DONE: done high for exactly one cycle, then IDLE; a new grant is possible from the cycle after DONE.
REQ-027 word_out and cod_en change only on the posedge; the coder samples on the negedge, giving half a cycle of setup.
REQ-028 en low: FSM, counters, word_out and target hold; cod_en, ack_a, ack_b and done are forced 0.
REQ-029 en high again: resume from the frozen count with no lost or duplicated step.

Reset
REQ-030 rst high sets immediately: state=IDLE, word_out=RST_WORD, target=RST_WORD, counters=0, and cod_en, ack_a, ack_b, done, busy=0.
REQ-031 rst mid-RAMP or mid-SETTLE aborts the operation; no ack or done follows the reset release.
REQ-032 After rst falls, the first grant is possible on the first posedge with a request present.

Structure
REQ-033 A shared package dco_pkg holds the FSM state typedef, the word width constant (5), and the MAX default.
REQ-034 A single sub-module dco_step_timer (load, enable, terminal-count output) implements both the step counter and the settle counter, instanced twice.
REQ-035 The arbitration and FSM stay in the top module; the block contains no combinational path from req to ack.

Verification
REQ-036 Reset, then req_a=1, word_a=10: ack_a 1 cycle later; word_out steps 0 to 10 every 4 cycles with 10 cod_en pulses; done 8 cycles after word_out=10.
REQ-037 From word_out=10, req_b=1, word_b=3: 7 down-steps to 3, then done; ack_a never asserts.
REQ-038 req_a=1, word_a=5 and req_b=1, word_b=20 in the same cycle: ack_a first, ramp to 5; after done, ack_b and ramp to 20.
REQ-039 word_a=31: target clamps to 25; word_out never exceeds 25.
REQ-040 Ramp in progress, en=0 for 6 cycles: word_out frozen and cod_en=0 throughout; step spacing still 4 cycles overall after en returns.
REQ-041 rst pulse during RAMP at word_out=7: word_out=0 and busy=0 immediately; no done after release.

Source files
------------

// File: rtl/dco_pkg.sv
// Shared types and constants for the DCO tuning-word sequencer.
package dco_pkg;

  localparam int WORD_W      = 5;
  localparam int MAX_DEFAULT = 25;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } dco_state_e;

  // Limit a requested target word to the largest legal tuning word.
  function automatic word_t clamp_word(input word_t w, input word_t lim);
    return (w > lim) ? lim : w;
  endfunction

endpackage

// File: rtl/dco_word_seq_if.sv
// Request/grant and coder-side signals of the tuning-word sequencer.
interface dco_word_seq_if;
  import dco_pkg::*;

  logic  en;
  logic  req_a;
  word_t word_a;
  logic  req_b;
  word_t word_b;
  logic  ack_a;
  logic  ack_b;
  logic  busy;
  logic  done;
  word_t word_out;
  logic  cod_en;

  modport master (
    output en, req_a, word_a, req_b, word_b,
    input  ack_a, ack_b, busy, done, word_out, cod_en
  );

  modport slave (
    input  en, req_a, word_a, req_b, word_b,
    output ack_a, ack_b, busy, done, word_out, cod_en
  );

endinterface

// File: rtl/dco_step_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at LIMIT.
module dco_step_timer #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] LIMIT_W = LIMIT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;

  // Count register: load clears, enable advances by one.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples the pre-edge values of its neighbours.
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc = (count_q == LIMIT_W);

endmodule

// File: rtl/dco_word_seq.sv
// Two-requester arbiter and ramp/settle sequencer driving the DCO tuning word.
module dco_word_seq
  import dco_pkg::*;
#(
  parameter int MAX        = MAX_DEFAULT,
  parameter int STEP_DIV   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int RST_WORD   = 0
) (
  input logic            clk,
  input logic            rst,
  dco_word_seq_if.slave  bus
);

  localparam word_t MAX_W      = word_t'(MAX);
  localparam word_t RST_W      = word_t'(RST_WORD);
  // SETTLE_CYC of 0 and 1 both leave SETTLE on the first counted edge.
  localparam int    SETTLE_LIM = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;

  dco_state_e state_q, state_d;
  word_t      word_q, word_d;
  word_t      target_q, target_d;
  word_t      step_word;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       cod_en_q, cod_en_d;
  logic       step_load, step_inc, step_tc;
  logic       settle_load, settle_inc, settle_tc;

  dco_step_timer #(.WIDTH(4), .LIMIT(STEP_DIV - 1)) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (step_load),
    .enable (step_inc),
    .tc     (step_tc)
  );

  dco_step_timer #(.WIDTH(8), .LIMIT(SETTLE_LIM)) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (settle_load),
    .enable (settle_inc),
    .tc     (settle_tc)
  );

  // One LSB toward the target; only used while word and target differ,
  // so the result stays between them and cannot wrap.
  assign step_word = (word_q < target_q) ? word_q + word_t'(1) : word_q - word_t'(1);

  // Next-state, arbitration and pulse generation; en low leaves everything held.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    word_d      = word_q;
    target_d    = target_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    cod_en_d    = 1'b0;
    step_load   = 1'b0;
    step_inc    = 1'b0;
    settle_load = 1'b0;
    settle_inc  = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_a) begin
            ack_a_d   = 1'b1;
            target_d  = clamp_word(bus.word_a, MAX_W);
            state_d   = ST_RAMP;
            step_load = 1'b1;
          end else if (bus.req_b) begin
            ack_b_d   = 1'b1;
            target_d  = clamp_word(bus.word_b, MAX_W);
            state_d   = ST_RAMP;
            step_load = 1'b1;
          end
        end
        ST_RAMP: begin
          if (word_q == target_q) begin
            state_d     = ST_SETTLE;
            settle_load = 1'b1;
          end else if (step_tc) begin
            word_d    = step_word;
            cod_en_d  = 1'b1;
            step_load = 1'b1;
            // Landing on the target starts the settle period on the same edge.
            if (step_word == target_q) begin
              state_d     = ST_SETTLE;
              settle_load = 1'b1;
            end
          end else begin
            step_inc = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_tc) state_d = ST_DONE;
          else           settle_inc = 1'b1;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, word and pulse registers; pulses self-clear on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= RST_W;
      target_q <= RST_W;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      cod_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      target_q <= target_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      cod_en_q <= cod_en_d;
    end
  end

  // Pulses are masked while disabled so a freeze never emits a strobe.
  assign bus.ack_a    = ack_a_q & bus.en;
  assign bus.ack_b    = ack_b_q & bus.en;
  assign bus.cod_en   = cod_en_q & bus.en;
  assign bus.done     = (state_q == ST_DONE) & bus.en;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.word_out = word_q;

endmodule

// File: tb/tb_dco_word_seq.sv
// Self-checking bench for dco_word_seq against a schedule-level reference model.
module tb_dco_word_seq;

  localparam int SD   = 4;   // cycles per step
  localparam int SC   = 8;   // settle cycles
  localparam int MAXV = 25;  // clamp value

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   model_word;

  dco_word_seq_if bus ();

  dco_word_seq #(
    .MAX        (MAXV),
    .STEP_DIV   (SD),
    .SETTLE_CYC (SC),
    .RST_WORD   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request/grant/ramp/settle/done transaction. The model tracks the
  // number of enabled edges since the grant and derives every expected
  // output from that count: steps every SD edges, settle of SC edges.
  task automatic run_txn(input bit use_a, input int w, input int freeze_at, input int freeze_len);
    int w0, t, n, dir, done_c, c, frz_cnt, guard, steps, exp_word, settle;
    bit frz_done, edge_en, exp_cod, exp_done;
    w0     = model_word;
    t      = (w > MAXV) ? MAXV : w;
    n      = (t > w0) ? t - w0 : w0 - t;
    dir    = (t > w0) ? 1 : -1;
    settle = (SC < 1) ? 1 : SC;
    done_c = (n == 0) ? 1 + settle : SD * n + settle;
    if (use_a) begin bus.req_a = 1'b1; bus.word_a = 5'(w); end
    else       begin bus.req_b = 1'b1; bus.word_b = 5'(w); end
    @(negedge clk);
    check(use_a ? "ack_a_grant" : "ack_b_grant", use_a ? bus.ack_a : bus.ack_b, 1);
    check("ack_other_at_grant", use_a ? bus.ack_b : bus.ack_a, 0);
    check("busy_at_grant", bus.busy, 1);
    check("word_at_grant", bus.word_out, w0);
    if (use_a) bus.req_a = 1'b0;
    else       bus.req_b = 1'b0;
    c = 0; frz_cnt = 0; frz_done = 1'b0; guard = 0;
    while (c <= done_c && guard < 4000) begin
      guard++;
      if (!frz_done && c == freeze_at && freeze_len > 0) begin
        bus.en   = 1'b0;
        frz_cnt  = freeze_len;
        frz_done = 1'b1;
      end
      edge_en = bus.en;
      @(negedge clk);
      if (edge_en) c++;
      steps    = (c / SD > n) ? n : c / SD;
      exp_word = w0 + dir * steps;
      exp_cod  = edge_en && (c % SD == 0) && (c / SD >= 1) && (c / SD <= n);
      exp_done = edge_en && (c == done_c);
      check("word_out", bus.word_out, exp_word);
      check("cod_en", bus.cod_en, exp_cod);
      check("done", bus.done, exp_done);
      check("busy", bus.busy, c <= done_c);
      check("ack_a_quiet", bus.ack_a, 0);
      check("ack_b_quiet", bus.ack_b, 0);
      if (!edge_en) begin
        frz_cnt--;
        if (frz_cnt == 0) bus.en = 1'b1;
      end
    end
    check("txn_within_bound", guard < 4000, 1);
    bus.en     = 1'b1;
    model_word = t;
  endtask

  initial begin
    int found;
    n_tests    = 0;
    n_fail     = 0;
    model_word = 0;
    rst        = 1'b1;
    bus.en     = 1'b1;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.word_a = '0;
    bus.word_b = '0;

    // Reset state.
    #1;
    check("rst_word", bus.word_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cod_en", bus.cod_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_ack_a", bus.ack_a, 0);
    check("rst_ack_b", bus.ack_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Calibration ramp 0 -> 10, then tracking ramp down to 3.
    run_txn(1'b1, 10, -1, 0);
    run_txn(1'b0, 3, -1, 0);

    // Simultaneous requests: a wins, b is served after a's done.
    bus.req_b  = 1'b1;
    bus.word_b = 5'd20;
    run_txn(1'b1, 5, -1, 0);
    run_txn(1'b0, 20, -1, 0);

    // Clamp to MAX.
    run_txn(1'b1, 31, -1, 0);

    // Freeze for 6 cycles right after a step, mid-ramp.
    run_txn(1'b0, 2, 8, 6);

    // Zero-step transaction.
    run_txn(1'b1, model_word, -1, 0);

    // Randomized transactions, some with freezes.
    for (int i = 0; i < 8; i++) begin
      int w, fa, fl;
      w  = int'($urandom_range(0, 31));
      fa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      fl = int'($urandom_range(1, 6));
      run_txn($urandom_range(0, 1) == 1, w, fa, fl);
    end

    // Reset mid-ramp at word_out = 7.
    run_txn(1'b1, 0, -1, 0);
    bus.req_a  = 1'b1;
    bus.word_a = 5'd20;
    @(negedge clk);
    bus.req_a = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bus.word_out == 5'd7) found = 1;
    end
    check("reached_word_7", found, 1);
    #2 rst = 1'b1;
    #1;
    check("midramp_rst_word", bus.word_out, 0);
    check("midramp_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst        = 1'b0;
    model_word = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_done", bus.done, 0);
      check("post_rst_ack_a", bus.ack_a, 0);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_word", bus.word_out, 0);
    end

    // Normal operation resumes after the abort.
    run_txn(1'b1, 4, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
